// File: rtl/imem_arbiter_if.sv
// Purpose : request/response/memory bundle between two requesters, the
//           instruction-memory arbiter and the synchronous-read memory.
// Ports   : slave = arbiter view; master = requesters + memory view.
// Latency : n/a (wiring only); backpressure carried by the ready signals.
interface imem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // request channels
   logic              i_req0_valid;
   logic              i_req1_valid;
   logic [ADDR_W-1:0] i_req0_addr;
   logic [ADDR_W-1:0] i_req1_addr;
   logic              o_req0_ready;
   logic              o_req1_ready;

   // response channels
   logic              o_rsp0_valid;
   logic              o_rsp1_valid;
   logic [DATA_W-1:0] o_rsp0_data;
   logic [DATA_W-1:0] o_rsp1_data;
   logic              o_rsp0_err;
   logic              o_rsp1_err;
   logic              i_rsp0_ready;
   logic              i_rsp1_ready;

   // memory side and status
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_stop;
   logic [DATA_W-1:0] i_mem_data;
   logic [15:0]       o_stall_cnt;

   modport slave (
      input  i_req0_valid, i_req1_valid, i_req0_addr, i_req1_addr,
      output o_req0_ready, o_req1_ready,
      output o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data,
      output o_rsp0_err, o_rsp1_err,
      input  i_rsp0_ready, i_rsp1_ready,
      output o_mem_addr, o_mem_stop,
      input  i_mem_data,
      output o_stall_cnt
   );

   modport master (
      output i_req0_valid, i_req1_valid, i_req0_addr, i_req1_addr,
      input  o_req0_ready, o_req1_ready,
      input  o_rsp0_valid, o_rsp1_valid, o_rsp0_data, o_rsp1_data,
      input  o_rsp0_err, o_rsp1_err,
      output i_rsp0_ready, i_rsp1_ready,
      input  o_mem_addr, o_mem_stop,
      output i_mem_data,
      input  o_stall_cnt
   );
endinterface

// File: rtl/imem_arbiter.sv
// Purpose : two-port round-robin arbiter/sequencer for a single-port,
//           one-cycle-latency instruction memory (err on addr >= DEPTH).
// Latency : response valid the cycle after grant; held until consumed.
// Backpressure: an unconsumed response freezes the memory (stop=1) and
//           blocks all grants; consume + new grant in one cycle is allowed.
// Ports   : clk, rst (async, active-high); bus = imem_arbiter_if.slave.
module imem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2048
) (
   input  logic               clk,
   input  logic               rst,
   imem_arbiter_if.slave      bus
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

   state_t      state_q, state_d;
   logic        own_q, own_d;     // port that owns the outstanding response
   logic        err_q, err_d;     // outstanding response is out of range
   logic        pri_q, pri_d;     // port with priority on contention
   logic [15:0] stall_q;

   logic busy, rsp0_vld, rsp1_vld, consumed, free;
   logic gnt0, gnt1, stall_inc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         own_q   <= 1'b0;
         err_q   <= 1'b0;
         pri_q   <= 1'b0;
         stall_q <= 16'd0;
      end else begin
         state_q <= state_d;
         own_q   <= own_d;
         err_q   <= err_d;
         pri_q   <= pri_d;
         if (stall_inc && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
      end
   end

   always_comb begin
      busy      = (state_q == BUSY);
      rsp0_vld  = busy & ~own_q;
      rsp1_vld  = busy & own_q;
      consumed  = (rsp0_vld & bus.i_rsp0_ready) | (rsp1_vld & bus.i_rsp1_ready);
      // Reset gates the grant so ready stays low while rst is held,
      // even though the state already reads IDLE.
      free      = ~rst & (~busy | consumed);
      gnt0      = free & bus.i_req0_valid & (~bus.i_req1_valid | ~pri_q);
      gnt1      = free & bus.i_req1_valid & (~bus.i_req0_valid | pri_q);
      stall_inc = (bus.i_req0_valid & ~gnt0) | (bus.i_req1_valid & ~gnt1);

      state_d = state_q;
      own_d   = own_q;
      err_d   = err_q;
      pri_d   = pri_q;
      if (gnt0 | gnt1) begin
         state_d = BUSY;
         own_d   = gnt1;
         err_d   = gnt1 ? (bus.i_req1_addr >= DEPTH_A) : (bus.i_req0_addr >= DEPTH_A);
         pri_d   = gnt0;   // priority passes to the other port
      end else if (free) begin
         state_d = IDLE;
      end
   end

   assign bus.o_req0_ready = gnt0;
   assign bus.o_req1_ready = gnt1;

   assign bus.o_mem_addr = gnt1 ? bus.i_req1_addr :
                           gnt0 ? bus.i_req0_addr : '0;
   // Holding the memory whenever nothing is granted keeps a pending
   // response stable without a local data register.
   assign bus.o_mem_stop = ~(gnt0 | gnt1);

   assign bus.o_rsp0_valid = rsp0_vld;
   assign bus.o_rsp1_valid = rsp1_vld;
   assign bus.o_rsp0_err   = rsp0_vld & err_q;
   assign bus.o_rsp1_err   = rsp1_vld & err_q;
   assign bus.o_rsp0_data  = (rsp0_vld & ~err_q) ? bus.i_mem_data : '0;
   assign bus.o_rsp1_data  = (rsp1_vld & ~err_q) ? bus.i_mem_data : '0;

   assign bus.o_stall_cnt = stall_q;

endmodule
